// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared encodings and helpers for the hazard/stall controller
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

   localparam logic [1:0] TUSE_NEVER = 2'd3;

   localparam logic MD_OP_MULT = 1'b0;
   localparam logic MD_OP_DIV  = 1'b1;

   // Producer Tnew as seen from the E stage; M stage is one less, floored at 0
   localparam logic [1:0] TNEW_ALU_E  = 2'd1;
   localparam logic [1:0] TNEW_LOAD_E = 2'd2;
   localparam logic [1:0] TNEW_MFHI_E = 2'd1;
   localparam logic [1:0] TNEW_ALU_M  = 2'd0;
   localparam logic [1:0] TNEW_LOAD_M = 2'd1;
   localparam logic [1:0] TNEW_MFHI_M = 2'd0;

   typedef enum logic {
      MD_MULT = 1'b0,
      MD_DIV  = 1'b1
   } md_op_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Operand needed before the pending producer can deliver it
   function automatic logic src_conflict(input logic [4:0] src, input logic [1:0] tuse,
                                         input logic [4:0] a3,  input logic [1:0] tnew);
      return (src == a3) && (tuse < tnew);
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_timer.sv
// ============================================================================
// md_busy_timer : down-counter tracking occupancy of the multi-cycle mult/div
// Rev 1.0
// ============================================================================
`default_nettype none

module md_busy_timer
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic op_i,
   output logic busy_o
);

   localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   logic [CNT_W-1:0] md_cnt_q;
   logic [CNT_W-1:0] md_cnt_d;

   // A start arriving while the unit is still counting is dropped, not reloaded
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (md_cnt_q == '0) begin
         if (start_i) begin
            md_cnt_d = (op_i == MD_OP_DIV) ? DIV_LOAD : MULT_LOAD;
         end
      end else begin
         md_cnt_d = md_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         md_cnt_q <= '0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

   assign busy_o = (md_cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// hazard_stall_ctrl : Tuse/Tnew data-hazard and mult/div stall controller
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int PERF_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        d_rs,
   input  logic [4:0]        d_rt,
   input  logic [1:0]        d_tuse_rs,
   input  logic [1:0]        d_tuse_rt,
   input  logic              d_is_md,
   input  logic [4:0]        e_a3,
   input  logic [4:0]        m_a3,
   input  logic [1:0]        e_tnew,
   input  logic [1:0]        m_tnew,
   input  logic              e_md_start,
   input  logic              e_md_op,
   output logic              pc_en,
   output logic              d_en,
   output logic              e_flush,
   output logic              md_busy,
   output logic [PERF_W-1:0] stall_count
);

   logic stall_rs;
   logic stall_rt;
   logic stall_md;
   logic stall;

   logic [PERF_W-1:0] stall_count_q;
   logic [PERF_W-1:0] stall_count_d;

   md_busy_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_timer (
      .clk     (clk),
      .rst     (rst),
      .start_i (e_md_start),
      .op_i    (e_md_op),
      .busy_o  (md_busy)
   );

   // $0 is hardwired, so a write to it never creates a dependency
   always_comb begin
      stall_rs = (d_rs != 5'd0) &&
                 (src_conflict(d_rs, d_tuse_rs, e_a3, e_tnew) ||
                  src_conflict(d_rs, d_tuse_rs, m_a3, m_tnew));
      stall_rt = (d_rt != 5'd0) &&
                 (src_conflict(d_rt, d_tuse_rt, e_a3, e_tnew) ||
                  src_conflict(d_rt, d_tuse_rt, m_a3, m_tnew));
      stall_md = d_is_md && (md_busy || e_md_start);
      stall    = stall_rs || stall_rt || stall_md;
   end

   assign pc_en   = ~stall;
   assign d_en    = ~stall;
   assign e_flush = stall;

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule

`default_nettype wire

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. Each cycle it compares the D-stage register reads against the E- and M-stage pending writes using Tuse/Tnew timing, and tracks the multi-cycle mult/div unit with an internal busy timer. From these it drives the fetch-unit PC enable, the D-register enable and the E-register flush. It sits beside the fetch unit and the pipeline registers and is the only source of their stall/flush controls.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu
- DIV_CYCLES, 10, busy duration for div/divu
- PERF_W, 32, width of stall performance counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- d_rs, d_rt  in  5 each  D-stage source register numbers
- d_tuse_rs, d_tuse_rt  in  2 each  cycles until D-stage operand is consumed; 3 = never used
- d_is_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- e_a3, m_a3  in  5 each  destination register in E / M; 0 = no write
- e_tnew, m_tnew  in  2 each  cycles until E / M result is available, already stage-adjusted
- e_md_start  in  1  E-stage mult/div issue pulse; one cycle per instruction
- e_md_op  in  1  0 = mult/multu, 1 = div/divu; valid with e_md_start
- pc_en  out  1  fetch-unit PC enable
- d_en  out  1  IF/ID register enable
- e_flush  out  1  ID/EX register clear (inserts bubble)
- md_busy  out  1  mult/div unit occupied
- stall_count  out  PERF_W  saturating count of stalled cycles

## Operation
- Data stall:
  - stall_rs = (d_rs != 0) & ((d_rs == e_a3 & d_tuse_rs < e_tnew) | (d_rs == m_a3 & d_tuse_rs < m_tnew)).
  - stall_rt is the same expression using d_rt and d_tuse_rt.
  - Register 0 never stalls.
- MD stall: stall_md = d_is_md & (md_busy | e_md_start).
- stall = stall_rs | stall_rt | stall_md. Purely combinational from inputs and the busy state.
- Outputs: pc_en = d_en = ~stall; e_flush = stall.
- Busy timer, down-counter md_cnt sized for max(MULT_CYCLES, DIV_CYCLES):
  - e_md_start while md_cnt == 0: load MULT_CYCLES or DIV_CYCLES per e_md_op.
  - Otherwise decrement while nonzero.
  - md_busy = (md_cnt != 0).
- e_md_start while md_busy is illegal. It is ignored: no reload, and the counter keeps decrementing.
- stall_count increments on every clock edge where stall = 1. It saturates at all-ones and never wraps.

## Timing
- Reset: md_cnt = 0, md_busy = 0, stall_count = 0. Takes effect immediately, asynchronously, including mid-countdown.
- After reset, with all inputs idle (a3 = 0, no start): pc_en = 1, d_en = 1, e_flush = 0.
- Stall outputs have zero latency: same cycle as the causing inputs.
- Start accepted at edge t: md_busy is high for exactly N cycles following edge t (N = MULT_CYCLES or DIV_CYCLES), then falls.
- A D-stage md instruction is therefore held from the start cycle through the last busy cycle, i.e. N + 1 cycles. It proceeds in the cycle md_busy first reads 0.
- When the E and M stages both match with insufficient Tnew, stall still holds for a single cycle only; re-evaluation happens each cycle.
- Data stall and md stall together: a single stall with identical outputs, and stall_count increments once.

## Structure
- Shared package hazard_pkg:
  - TUSE_NEVER = 2'd3.
  - MD_OP_MULT = 1'b0, MD_OP_DIV = 1'b1.
  - Stage Tnew constants for ALU, load and mfhi/mflo producers.
- One sub-module: md_busy_timer, holding md_cnt, the load/decrement logic and md_busy.
- The comparator logic and the performance counter stay in the top module.

## Test plan
- Load-use: e_a3 = 8, e_tnew = 2, d_rs = 8, d_tuse_rs = 1 -> stall = 1, pc_en = 0, e_flush = 1. Set e_tnew = 1 -> stall = 0.
- $0 guard: d_rs = 0, e_a3 = 0, e_tnew = 2, d_tuse_rs = 0 -> no stall.
- Mult timing: e_md_start = 1, e_md_op = 0 at cycle 0 with d_is_md = 1 -> stall on cycles 0..5, md_busy high on cycles 1..5, pc_en = 1 on cycle 6. Repeat with div -> busy on cycles 1..10.
- Async reset mid-div: assert rst on cycle 4 between edges -> md_busy = 0 and stall_count = 0 immediately. Release -> no stall.
- Illegal restart: e_md_start while md_cnt = 3 -> counter continues 2, 1, 0 with no reload.
- Saturation: PERF_W = 4, hold stall for 20 cycles -> stall_count stops at 15.
